button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 50000: consecutive stable cycles needed before a debounced level changes; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of each debounce counter; SHALL satisfy 2^CNT_W > DEBOUNCE_CNT.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 ena  input  1  when low, holds all counters and FSM state.
REQ-006 btn_raw  input  4  asynchronous colour buttons, one-hot intent; bit0=red, bit1=green, bit2=blue, bit3=yellow.
REQ-007 start_raw  input  1  asynchronous start button.
REQ-008 btn_level  output  4  debounced button levels.
REQ-009 btn_pressed  output  1  one-cycle pulse, one per accepted press (feeds WAIT_STATE colour_in).
REQ-010 colour_val  output  2  encoded colour of the accepted press, valid while btn_pressed is high and held until the next accepted press.
REQ-011 invalid  output  1  one-cycle pulse on a multi-button press.
REQ-012 start_pulse  output  1  one-cycle pulse on the rising edge of debounced start.

Function
REQ-013 Each of the 5 raw inputs SHALL pass through a 2-flop synchronizer before debouncing.
REQ-014 Per input: the counter clears when the synced value equals the debounced value. Otherwise it increments; when it reaches DEBOUNCE_CNT-1, the debounced value toggles on the next edge and the counter clears.
REQ-015 Latency: a clean raw edge SHALL appear on btn_level exactly DEBOUNCE_CNT+2 edges later. Any glitch shorter than DEBOUNCE_CNT cycles SHALL not change btn_level.
REQ-016 Press FSM states: SETTLE, ARMED, HELD.
  - SETTLE -> ARMED when btn_level==0.
  - ARMED -> HELD when btn_level!=0.
  - HELD -> ARMED when btn_level==0.
REQ-017 On ARMED->HELD with exactly one bit of btn_level set, btn_pressed SHALL pulse on the following cycle. colour_val SHALL be 00/01/10/11 for bit 0/1/2/3.
REQ-018 On ARMED->HELD with more than one bit set, behaviour is governed by REQ-025/026.
REQ-019 Buttons added or changed while in HELD SHALL produce no pulse; a new press requires all buttons to be released first.
REQ-020 start_pulse SHALL be independent of the FSM. It SHALL pulse one cycle after the debounced start level rises 0->1.
REQ-021 With ena low, all counters, synchronizers and FSM state SHALL hold, and btn_pressed/invalid/start_pulse SHALL be 0.
REQ-022 Simultaneous press events and start events SHALL both be reported in the same cycle.

Reset
REQ-023 On a clk edge with rst_n low:
  - synchronizers, counters, btn_level, colour_val, btn_pressed, invalid and start_pulse go to 0;
  - the FSM goes to SETTLE.
REQ-024 Reset mid-press SHALL abort the press. A button held through reset SHALL debounce to 1 with FSM in ARMED and SHALL produce a press, because btn_level==0 at reset moves the FSM SETTLE->ARMED after one cycle.

Configuration
REQ-025 With BTN_MULTI_PRESS_INVALID_EN defined, a multi-bit press SHALL pulse invalid for one cycle, produce no btn_pressed, and leave colour_val unchanged.
REQ-026 Without BTN_MULTI_PRESS_INVALID_EN, invalid SHALL be tied 0 and a multi-bit press SHALL be accepted as the lowest-index set bit.

Structure
REQ-027 Shared package simon_pkg SHALL hold the colour encoding constants (COL_RED=2'b00, COL_GREEN=2'b01, COL_BLUE=2'b10, COL_YELLOW=2'b11), the press-FSM state typedef, and the DEBOUNCE_CNT default.
REQ-028 Sub-module debounce_bit (synchronizer + counter + level, parameterised by DEBOUNCE_CNT/CNT_W) SHALL be instantiated 5 times; the FSM and encoding live in button_debounce.

Verification (DEBOUNCE_CNT=4)
REQ-029 The bench SHALL cover these directed scenarios:
  - btn_raw=4'b0100 at edge 0, held: btn_level[2]=1 after edge 6, btn_pressed=1 for exactly the cycle after edge 7, colour_val=2'b10.
  - btn_raw[0] glitch high for 3 cycles: btn_level stays 0, no pulse.
  - Hold blue, then add red, release both, press green: only two pulses, colour_val 10 then 01.
  - btn_raw=4'b0011 simultaneously: with macro, invalid pulses and there is no btn_pressed; without macro, btn_pressed with colour_val=00.
  - start_raw high while pressing yellow: start_pulse and btn_pressed are each seen once, colour_val=11.
  - rst_n low for 1 cycle mid-debounce with ena toggled low for 5 cycles afterwards: outputs are 0 after reset, latency is extended by exactly 5 cycles.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon button front end: colour codes,
// press-FSM states and the default debounce length.
package simon_pkg;

  localparam logic [1:0] COL_RED    = 2'b00;
  localparam logic [1:0] COL_GREEN  = 2'b01;
  localparam logic [1:0] COL_BLUE   = 2'b10;
  localparam logic [1:0] COL_YELLOW = 2'b11;

  localparam int DEFAULT_DEBOUNCE_CNT = 50000;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ARMED  = 2'd1,
    HELD   = 2'd2
  } press_state_t;

  // Lowest-index set bit wins; callers only use it with a non-zero level.
  function automatic logic [1:0] lowest_colour(input logic [3:0] lvl);
    if (lvl[0])      return COL_RED;
    else if (lvl[1]) return COL_GREEN;
    else if (lvl[2]) return COL_BLUE;
    else             return COL_YELLOW;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input channel: 2-flop synchronizer, then a counter that flips the
// level once the synced value has disagreed with it for DEBOUNCE_CNT edges.
module debounce_bit
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else if (ena) begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_debounce.sv
// Debounces four colour buttons and start, turns each fresh press into one
// colour pulse. Define BTN_MULTI_PRESS_INVALID_EN to flag multi-button presses.
module button_debounce
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEFAULT_DEBOUNCE_CNT,
  parameter int CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] btn_raw,
  input  logic       start_raw,
  output logic [3:0] btn_level,
  output logic       btn_pressed,
  output logic [1:0] colour_val,
  output logic       invalid,
  output logic       start_pulse
);

  logic         start_level;
  logic         start_level_q;
  logic         pressed_q;
  logic         start_pulse_q;
  logic         press_evt;
  logic         accept;
  press_state_t state;
  press_state_t state_nxt;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce_bit #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W)
    ) u_btn (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .raw  (btn_raw[i]),
      .level(btn_level[i])
    );
  end

  debounce_bit #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .CNT_W       (CNT_W)
  ) u_start (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .raw  (start_raw),
    .level(start_level)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SETTLE;
    end else if (ena) begin
      state <= state_nxt;
    end
  end

  // A press is only recognised on the ARMED->HELD edge, so a new press
  // needs a full release first.
  always_comb begin
    state_nxt = state;
    press_evt = 1'b0;
    case (state)
      SETTLE: if (btn_level == 4'd0) state_nxt = ARMED;
      ARMED: begin
        if (btn_level != 4'd0) begin
          state_nxt = HELD;
          press_evt = 1'b1;
        end
      end
      HELD:    if (btn_level == 4'd0) state_nxt = ARMED;
      default: state_nxt = SETTLE;
    endcase
  end

`ifdef BTN_MULTI_PRESS_INVALID_EN
  logic multi;
  logic invalid_q;

  assign multi  = |(btn_level & (btn_level - 4'd1));
  assign accept = press_evt & ~multi;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      invalid_q <= 1'b0;
    end else if (ena) begin
      invalid_q <= press_evt & multi;
    end else begin
      invalid_q <= 1'b0;
    end
  end

  assign invalid = invalid_q & ena;
`else
  assign accept  = press_evt;
  assign invalid = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pressed_q     <= 1'b0;
      colour_val    <= COL_RED;
      start_level_q <= 1'b0;
      start_pulse_q <= 1'b0;
    end else if (ena) begin
      pressed_q     <= accept;
      start_level_q <= start_level;
      start_pulse_q <= start_level & ~start_level_q;
      if (accept) colour_val <= lowest_colour(btn_level);
    end else begin
      pressed_q     <= 1'b0;
      start_pulse_q <= 1'b0;
    end
  end

  // Masking with ena keeps pulses silent for the whole time ena is low.
  assign btn_pressed = pressed_q & ena;
  assign start_pulse = start_pulse_q & ena;

endmodule

// File: tb/tb_button_debounce.sv
// Directed scenarios plus random bursts for button_debounce, checked cycle by
// cycle against a window-based debounce model and a release-armed press model.
module tb_button_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] btn_raw;
  logic       start_raw;
  logic [3:0] btn_level;
  logic       btn_pressed;
  logic [1:0] colour_val;
  logic       invalid;
  logic       start_pulse;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [4:0] m_lev;
  logic [D:0] m_hist [5];
  logic       m_armed, m_sprev, m_pressed, m_invalid, m_spulse;
  logic [1:0] m_colour;

  // Observation counters for the directed scenarios
  int         pcount, icount, scount, both;
  logic [1:0] colour_log [$];

  button_debounce #(.DEBOUNCE_CNT(D), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .btn_raw    (btn_raw),
    .start_raw  (start_raw),
    .btn_level  (btn_level),
    .btn_pressed(btn_pressed),
    .colour_val (colour_val),
    .invalid    (invalid),
    .start_pulse(start_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Level flips once the synced samples of the last D enabled edges all
  // disagree with it; a press happens on the first non-zero level after
  // an all-released level.
  task automatic model_edge();
    logic [4:0] raw5;
    logic [4:0] nlev;
    logic [3:0] old;
    logic       ev;
    logic [1:0] lc;
    if (!rst_n) begin
      m_lev = '0;
      for (int i = 0; i < 5; i++) m_hist[i] = '0;
      m_armed = 1'b0; m_sprev = 1'b0;
      m_pressed = 1'b0; m_invalid = 1'b0; m_spulse = 1'b0;
      m_colour = 2'b00;
    end else if (!ena) begin
      m_pressed = 1'b0; m_invalid = 1'b0; m_spulse = 1'b0;
    end else begin
      raw5 = {start_raw, btn_raw};
      for (int i = 0; i < 5; i++) begin
        nlev[i] = m_lev[i];
        if (m_hist[i][D:1] == {D{~m_lev[i]}}) nlev[i] = ~m_lev[i];
        m_hist[i] = {m_hist[i][D-1:0], raw5[i]};
      end
      old = m_lev[3:0];
      ev  = 1'b0;
      if (old == 4'd0) m_armed = 1'b1;
      else if (m_armed) begin ev = 1'b1; m_armed = 1'b0; end
      lc = 2'b00;
      for (int b = 3; b >= 0; b--) if (old[b]) lc = 2'(b);
      m_pressed = 1'b0;
      m_invalid = 1'b0;
`ifdef BTN_MULTI_PRESS_INVALID_EN
      if (ev && $countones(old) == 1) begin m_pressed = 1'b1; m_colour = lc; end
      else if (ev) m_invalid = 1'b1;
`else
      if (ev) begin m_pressed = 1'b1; m_colour = lc; end
`endif
      m_spulse = m_lev[4] & ~m_sprev;
      m_sprev  = m_lev[4];
      m_lev    = nlev;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("btn_level", btn_level, m_lev[3:0]);
    chk("btn_pressed", {3'b0, btn_pressed}, {3'b0, m_pressed});
    chk("colour_val", {2'b0, colour_val}, {2'b0, m_colour});
    chk("invalid", {3'b0, invalid}, {3'b0, m_invalid});
    chk("start_pulse", {3'b0, start_pulse}, {3'b0, m_spulse});
    if (btn_pressed) begin pcount++; colour_log.push_back(colour_val); end
    if (invalid) icount++;
    if (start_pulse) scount++;
    if (btn_pressed && start_pulse) both++;
  endtask

  task automatic clear_obs();
    pcount = 0; icount = 0; scount = 0; both = 0;
    colour_log.delete();
  endtask

  task automatic idle(input int n);
    btn_raw = 4'b0000; start_raw = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    int first;
    int sel;
    int len;
    rst_n = 1'b0; ena = 1'b1; btn_raw = 4'b0000; start_raw = 1'b0;
    clear_obs();

    // Reset state
    tick(); tick();
    chk("rst_level", btn_level, 4'b0000);
    chk("rst_pressed", {3'b0, btn_pressed}, 4'b0000);
    rst_n = 1'b1;
    idle(3);

    // S1: blue press latency
    clear_obs();
    btn_raw = 4'b0100;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 5) chk_int("s1_level_e5", int'(btn_level[2]), 0);
      if (t == 6) chk_int("s1_level_e6", int'(btn_level[2]), 1);
      if (t == 7) chk_int("s1_pressed_e7", int'(btn_pressed), 1);
      if (t == 7) chk("s1_colour_e7", {2'b0, colour_val}, 4'b0010);
      if (t == 8) chk_int("s1_pressed_e8", int'(btn_pressed), 0);
    end
    chk_int("s1_pcount", pcount, 1);
    idle(10);

    // S2: 3-cycle glitch on red
    clear_obs();
    btn_raw = 4'b0001;
    repeat (3) tick();
    idle(12);
    chk_int("s2_pcount", pcount, 0);
    chk("s2_level", btn_level, 4'b0000);

    // S3: blue, add red, release, green
    clear_obs();
    btn_raw = 4'b0100; repeat (10) tick();
    btn_raw = 4'b0101; repeat (10) tick();
    idle(10);
    btn_raw = 4'b0010; repeat (10) tick();
    idle(10);
    chk_int("s3_pcount", pcount, 2);
    if (colour_log.size() == 2) begin
      chk("s3_colour0", {2'b0, colour_log[0]}, 4'b0010);
      chk("s3_colour1", {2'b0, colour_log[1]}, 4'b0001);
    end

    // S4: simultaneous red+green
    clear_obs();
    btn_raw = 4'b0011; repeat (10) tick();
    idle(10);
`ifdef BTN_MULTI_PRESS_INVALID_EN
    chk_int("s4_icount", icount, 1);
    chk_int("s4_pcount", pcount, 0);
`else
    chk_int("s4_icount", icount, 0);
    chk_int("s4_pcount", pcount, 1);
    chk("s4_colour", {2'b0, colour_val}, 4'b0000);
`endif

    // S5: start together with yellow
    clear_obs();
    btn_raw = 4'b1000; start_raw = 1'b1;
    repeat (10) tick();
    idle(12);
    chk_int("s5_pcount", pcount, 1);
    chk_int("s5_scount", scount, 1);
    chk_int("s5_same_cycle", both, 1);
    chk("s5_colour", {2'b0, colour_val}, 4'b0011);

    // S6: reset mid-debounce, then 5 cycles of ena low
    clear_obs();
    btn_raw = 4'b0010;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("s6_rst_level", btn_level, 4'b0000);
    chk("s6_rst_colour", {2'b0, colour_val}, 4'b0000);
    rst_n = 1'b1; ena = 1'b0;
    first = 0;
    for (int t = 1; t <= 16; t++) begin
      if (t == 6) ena = 1'b1;
      tick();
      if (btn_pressed && first == 0) first = t;
      if (t == 10) chk_int("s6_level_10", int'(btn_level[1]), 0);
      if (t == 11) chk_int("s6_level_11", int'(btn_level[1]), 1);
    end
    chk_int("s6_press_edge", first, 12);
    idle(10);

    // Random bursts
    for (int k = 0; k < 120; k++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: btn_raw = 4'b0000;
        1: btn_raw = 4'b0001;
        2: btn_raw = 4'b0010;
        3: btn_raw = 4'b0100;
        4: btn_raw = 4'b1000;
        5: btn_raw = 4'($urandom);
        default: ;
      endcase
      start_raw = ($urandom_range(0, 3) == 0);
      ena       = ($urandom_range(0, 9) != 0);
      rst_n     = ($urandom_range(0, 39) != 0);
      len = rst_n ? int'($urandom_range(1, 10)) : 1;
      repeat (len) tick();
      rst_n = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
